// File: rtl/controlador_interrupcao_if.sv
// controlador_interrupcao_if: request/acknowledge/clear handshake between the interrupt controller and the control unit.
interface controlador_interrupcao_if #(
    parameter int NUM_SRC = 4,
    parameter int CODE_W  = 3
);
    logic [NUM_SRC-1:0] irq_src;
    logic               timer_en;
    logic               inta;
    logic               clear_intr;
    logic               intr;
    logic [CODE_W-1:0]  int_code;
    logic [NUM_SRC:0]   pending;
    logic               busy;

    modport master (
        input  irq_src, timer_en, inta, clear_intr,
        output intr, int_code, pending, busy
    );

    modport slave (
        output irq_src, timer_en, inta, clear_intr,
        input  intr, int_code, pending, busy
    );
endinterface

// File: rtl/controlador_interrupcao.sv
// controlador_interrupcao: fixed-priority interrupt controller with quantum timer and intr/inta/clear handshake.
module controlador_interrupcao #(
    parameter int NUM_SRC = 4,
    parameter int CODE_W  = 3,
    parameter int QUANTUM = 1000,
    parameter int TMR_W   = 16
) (
    input  logic clk,
    input  logic rst,
    controlador_interrupcao_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_q;
    logic [TMR_W-1:0]   cnt;
    logic [NUM_SRC:0]   pend;
    logic               intr_r;
    logic               busy_r;
    logic [CODE_W-1:0]  code_r;
    logic [CODE_W-1:0]  win;
    logic               tmr_hit;
    logic [NUM_SRC:0]   set_vec;
    logic [NUM_SRC:0]   clr_vec;
    logic               grant;

    assign tmr_hit = bus.timer_en && cnt == TMR_W'(QUANTUM - 1);
    assign set_vec = {bus.irq_src & ~irq_q, tmr_hit};
    assign grant   = state == IDLE && |pend;
    assign clr_vec = grant ? {{NUM_SRC{1'b0}}, 1'b1} << win : '0;

    // descending scan so the lowest pending index is the one left in win
    always_comb begin
        win = '0;
        for (int i = NUM_SRC; i >= 0; i--)
            if (pend[i]) win = CODE_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= '0;
            cnt   <= '0;
            pend  <= '0;
        end else begin
            irq_q <= bus.irq_src;
            cnt   <= !bus.timer_en || tmr_hit ? '0 : cnt + 1'b1;
            pend  <= (pend & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            intr_r <= 1'b0;
            busy_r <= 1'b0;
            code_r <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state  <= REQ;
                    intr_r <= 1'b1;
                    busy_r <= 1'b1;
                    code_r <= win + CODE_W'(1);
                end
                REQ: if (bus.clear_intr) begin
                    state  <= IDLE;
                    intr_r <= 1'b0;
                    busy_r <= 1'b0;
                    code_r <= '0;
                end else if (bus.inta) begin
                    state  <= SERVICE;
                    intr_r <= 1'b0;
                end
                SERVICE: if (bus.clear_intr) begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    code_r <= '0;
                end
                default: begin
                    state  <= IDLE;
                    intr_r <= 1'b0;
                    busy_r <= 1'b0;
                    code_r <= '0;
                end
            endcase
        end
    end

    assign bus.intr     = intr_r;
    assign bus.int_code = code_r;
    assign bus.pending  = pend;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_controlador_interrupcao.sv
// tb_controlador_interrupcao: directed scenarios with hand-computed expectations (QUANTUM overridden to 4).
module tb_controlador_interrupcao;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails = 0;

    controlador_interrupcao_if #(.NUM_SRC(4), .CODE_W(3)) bus ();

    controlador_interrupcao #(.NUM_SRC(4), .CODE_W(3), .QUANTUM(4), .TMR_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.irq_src = 4'b0001; bus.timer_en = 1'b0; bus.inta = 1'b0; bus.clear_intr = 1'b0;
        rst = 1'b0;
        tick(); tick();
        checks++; if (bus.intr !== 1'b0 || bus.int_code !== 3'd0 || bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_state: intr=%b code=%0d pending=%b busy=%b, required 0/0/00000/0", bus.intr, bus.int_code, bus.pending, bus.busy);
        end
        rst = 1'b1;
        tick();
        checks++; if (bus.pending !== 5'b00010 || bus.intr !== 1'b0) begin
            fails++; $display("FAIL reset_held_line_pend: pending=%b intr=%b, required 00010/0", bus.pending, bus.intr);
        end
        tick();
        checks++; if (bus.intr !== 1'b1 || bus.int_code !== 3'd2 || bus.pending !== 5'b0 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL reset_first_issue: intr=%b code=%0d pending=%b busy=%b, required 1/2/00000/1", bus.intr, bus.int_code, bus.pending, bus.busy);
        end
        bus.inta = 1'b1; tick();
        bus.inta = 1'b0; bus.clear_intr = 1'b1; tick();
        bus.clear_intr = 1'b0; bus.irq_src = 4'b0; tick();
    endtask

    task automatic test_priority();
        logic [2:0] exp_codes [3] = '{3'd1, 3'd2, 3'd4};
        bus.timer_en = 1'b1;
        tick(); tick(); tick();
        bus.irq_src = 4'b0101;
        tick();
        bus.timer_en = 1'b0;
        checks++; if (bus.pending !== 5'b01011) begin
            fails++; $display("FAIL prio_pending: pending=%b, required 01011", bus.pending);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.intr !== 1'b1 || bus.int_code !== exp_codes[i]) begin
                fails++; $display("FAIL prio_issue_%0d: intr=%b code=%0d, required 1/%0d", i, bus.intr, bus.int_code, exp_codes[i]);
            end
            bus.inta = 1'b1; tick(); bus.inta = 1'b0;
            checks++; if (bus.intr !== 1'b0 || bus.int_code !== exp_codes[i] || bus.busy !== 1'b1) begin
                fails++; $display("FAIL prio_service_%0d: intr=%b code=%0d busy=%b, required 0/%0d/1", i, bus.intr, bus.int_code, bus.busy, exp_codes[i]);
            end
            bus.clear_intr = 1'b1; tick(); bus.clear_intr = 1'b0;
            checks++; if (bus.intr !== 1'b0 || bus.int_code !== 3'd0 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL prio_gap_%0d: intr=%b code=%0d busy=%b, required 0/0/0", i, bus.intr, bus.int_code, bus.busy);
            end
            tick();
        end
        checks++; if (bus.intr !== 1'b0 || bus.pending !== 5'b0) begin
            fails++; $display("FAIL prio_drained: intr=%b pending=%b, required 0/00000", bus.intr, bus.pending);
        end
        bus.irq_src = 4'b0; tick();
    endtask

    task automatic test_timer_restart();
        bus.timer_en = 1'b1; tick(); tick();
        bus.timer_en = 1'b0; tick();
        bus.timer_en = 1'b1; tick(); tick(); tick();
        checks++; if (bus.pending !== 5'b0) begin
            fails++; $display("FAIL timer_restart_early: pending=%b, required 00000", bus.pending);
        end
        tick();
        bus.timer_en = 1'b0;
        checks++; if (bus.pending !== 5'b00001) begin
            fails++; $display("FAIL timer_restart_hit: pending=%b, required 00001", bus.pending);
        end
        tick();
        checks++; if (bus.intr !== 1'b1 || bus.int_code !== 3'd1) begin
            fails++; $display("FAIL timer_issue: intr=%b code=%0d, required 1/1", bus.intr, bus.int_code);
        end
    endtask

    task automatic test_cancel();
        bus.clear_intr = 1'b1; tick(); bus.clear_intr = 1'b0;
        checks++; if (bus.intr !== 1'b0 || bus.int_code !== 3'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL cancel_idle: intr=%b code=%0d busy=%b, required 0/0/0", bus.intr, bus.int_code, bus.busy);
        end
        tick(); tick();
        checks++; if (bus.intr !== 1'b0 || bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL cancel_no_reissue: intr=%b pending=%b busy=%b, required 0/00000/0", bus.intr, bus.pending, bus.busy);
        end
    endtask

    task automatic test_service_reclear();
        bus.irq_src = 4'b0010; tick(); tick();
        checks++; if (bus.intr !== 1'b1 || bus.int_code !== 3'd3) begin
            fails++; $display("FAIL reclear_issue: intr=%b code=%0d, required 1/3", bus.intr, bus.int_code);
        end
        bus.inta = 1'b1; tick(); bus.inta = 1'b0;
        bus.irq_src = 4'b0; tick();
        bus.irq_src = 4'b0010; bus.clear_intr = 1'b1; tick(); bus.clear_intr = 1'b0;
        checks++; if (bus.int_code !== 3'd0 || bus.intr !== 1'b0 || bus.pending !== 5'b00100 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reclear_set_wins: code=%0d intr=%b pending=%b busy=%b, required 0/0/00100/0", bus.int_code, bus.intr, bus.pending, bus.busy);
        end
        tick();
        checks++; if (bus.intr !== 1'b1 || bus.int_code !== 3'd3 || bus.pending !== 5'b0) begin
            fails++; $display("FAIL reclear_reissue: intr=%b code=%0d pending=%b, required 1/3/00000", bus.intr, bus.int_code, bus.pending);
        end
        bus.inta = 1'b1; tick(); bus.inta = 1'b0;
        bus.clear_intr = 1'b1; tick(); bus.clear_intr = 1'b0;
        bus.irq_src = 4'b0; tick();
    endtask

    task automatic test_reset_mid();
        bus.irq_src = 4'b0001; tick(); tick();
        bus.irq_src = 4'b0111; tick();
        bus.inta = 1'b1; tick(); bus.inta = 1'b0;
        checks++; if (bus.pending !== 5'b01100 || bus.busy !== 1'b1 || bus.int_code !== 3'd2 || bus.intr !== 1'b0) begin
            fails++; $display("FAIL mid_service_state: pending=%b busy=%b code=%0d intr=%b, required 01100/1/2/0", bus.pending, bus.busy, bus.int_code, bus.intr);
        end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.intr !== 1'b0 || bus.int_code !== 3'd0 || bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL mid_async_reset: intr=%b code=%0d pending=%b busy=%b, required 0/0/00000/0", bus.intr, bus.int_code, bus.pending, bus.busy);
        end
        bus.irq_src = 4'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.intr !== 1'b0 || bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL mid_requests_lost: intr=%b pending=%b busy=%b, required 0/00000/0", bus.intr, bus.pending, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_timer_restart();
        test_cancel();
        test_service_reclear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
